// File: rtl/motor_pwm_driver.sv
// Dual H-bridge driver with soft-start PWM ramp and forced dead-time on every stop or reversal.
// Inputs pass a 2-flop sync; pins and busy are registered. The left and right channels run independently on one shared PWM counter.
module motor_pwm_driver #(
  parameter int PWM_BITS = 8,
  parameter int RAMP_INC = 32,
  parameter int DUTY_MAX = 255,
  parameter int DEADTIME = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic len_in,
  input  logic ldir_in,
  input  logic ren_in,
  input  logic rdir_in,
  output logic l_in1,
  output logic l_in2,
  output logic r_in1,
  output logic r_in2,
  output logic l_busy,
  output logic r_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEADTIME - 1);
  localparam logic [PWM_BITS:0]   INC_W     = (PWM_BITS + 1)'(RAMP_INC);
  localparam logic [PWM_BITS:0]   MAX_W     = (PWM_BITS + 1)'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] MAX_N     = PWM_BITS'(DUTY_MAX);

  // Index 0 is the left channel, index 1 the right channel.
  logic [1:0] en_q1, en_s, dir_q1, dir_s;
  logic [PWM_BITS-1:0] cnt;
  logic pe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q1  <= '0;
      en_s   <= '0;
      dir_q1 <= '0;
      dir_s  <= '0;
    end else begin
      en_q1  <= {ren_in, len_in};
      en_s   <= en_q1;
      dir_q1 <= {rdir_in, ldir_in};
      dir_s  <= dir_q1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  assign pe = &cnt;

  for (genvar g = 0; g < 2; g++) begin : g_side
    logic [1:0]          state;
    logic [PWM_BITS-1:0] duty;
    logic                dir_lat;
    logic [DW-1:0]       dead_cnt;
    logic                abort;
    logic                pwm;
    logic                active;
    logic [PWM_BITS:0]   duty_sum;
    logic [PWM_BITS-1:0] duty_step;
    logic                pin1, pin2, busy;

    assign abort  = !en_s[g] || (dir_s[g] != dir_lat);
    assign pwm    = cnt < duty;
    assign active = (state == S_RAMP) || (state == S_RUN);

    // One extra bit so the saturating add never wraps past DUTY_MAX.
    assign duty_sum  = {1'b0, duty} + INC_W;
    assign duty_step = (duty_sum >= MAX_W) ? MAX_N : duty_sum[PWM_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= S_IDLE;
        duty     <= '0;
        dir_lat  <= 1'b0;
        dead_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            duty <= '0;
            if (en_s[g]) begin
              dir_lat <= dir_s[g];
              state   <= S_RAMP;
              busy    <= 1'b1;
            end
          end
          S_RAMP, S_RUN: begin
            // Abort wins over a coincident period end: duty is not stepped.
            if (abort) begin
              state    <= S_DEAD;
              duty     <= '0;
              dead_cnt <= DEAD_LOAD;
            end else if (state == S_RAMP && pe) begin
              duty <= duty_step;
              if (duty_step == MAX_N) state <= S_RUN;
            end
          end
          S_DEAD: begin
            duty <= '0;
            if (dead_cnt == '0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              dead_cnt <= dead_cnt - 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            duty  <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end

    // Only one pin can ever carry pwm, selected by the latched direction.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pin1 <= 1'b0;
        pin2 <= 1'b0;
      end else begin
        pin1 <= active && dir_lat && pwm;
        pin2 <= active && !dir_lat && pwm;
      end
    end
  end

  assign l_in1  = g_side[0].pin1;
  assign l_in2  = g_side[0].pin2;
  assign r_in1  = g_side[1].pin1;
  assign r_in2  = g_side[1].pin2;
  assign l_busy = g_side[0].busy;
  assign r_busy = g_side[1].busy;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed scenarios with literal expectations plus randomized commands
// checked every cycle against a behavioural model of the ramp/dead-time rules.
module tb_motor_pwm_driver;

  localparam int PERIOD   = 256;
  localparam int INC      = 32;
  localparam int DMAX     = 255;
  localparam int DEADTIME = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic len_in = 1'b0, ldir_in = 1'b0, ren_in = 1'b0, rdir_in = 1'b0;
  logic l_in1, l_in2, r_in1, r_in2, l_busy, r_busy;

  int tests = 0;
  int fails = 0;
  bit run_cmp = 1'b0;

  motor_pwm_driver dut (
    .clk(clk), .rst(rst),
    .len_in(len_in), .ldir_in(ldir_in), .ren_in(ren_in), .rdir_in(rdir_in),
    .l_in1(l_in1), .l_in2(l_in2), .r_in1(r_in1), .r_in2(r_in2),
    .l_busy(l_busy), .r_busy(r_busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: modes 0 idle, 1 ramp, 2 run, 3 dead. cyc = edges since reset release.
  int  cyc;
  int  m_mode[2], m_duty[2], m_dir[2], m_nper[2], m_dead_end[2];
  bit  [1:0] en_p1, en_p2, dir_p1, dir_p2;
  bit  [1:0] exp_in1, exp_in2, exp_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0;
      en_p1 = '0; en_p2 = '0; dir_p1 = '0; dir_p2 = '0;
      exp_in1 = '0; exp_in2 = '0; exp_busy = '0;
      for (int s = 0; s < 2; s++) begin
        m_mode[s] = 0; m_duty[s] = 0; m_dir[s] = 0; m_nper[s] = 0; m_dead_end[s] = 0;
      end
    end else begin
      int cnt_now;
      cnt_now = cyc % PERIOD;
      for (int s = 0; s < 2; s++) begin
        bit drive;
        drive = (m_mode[s] == 1 || m_mode[s] == 2) && (cnt_now < m_duty[s]);
        exp_in1[s] = drive && (m_dir[s] == 1);
        exp_in2[s] = drive && (m_dir[s] == 0);
        if (m_mode[s] == 0) begin
          if (en_p2[s]) begin
            m_dir[s] = dir_p2[s]; m_mode[s] = 1; m_nper[s] = 0; m_duty[s] = 0;
          end
        end else if (m_mode[s] == 3) begin
          if (cyc == m_dead_end[s]) m_mode[s] = 0;
        end else if (!en_p2[s] || (dir_p2[s] != m_dir[s])) begin
          m_mode[s] = 3; m_duty[s] = 0; m_dead_end[s] = cyc + DEADTIME;
        end else if (m_mode[s] == 1 && cnt_now == PERIOD - 1) begin
          m_nper[s]++;
          m_duty[s] = (m_nper[s] * INC > DMAX) ? DMAX : m_nper[s] * INC;
          if (m_duty[s] == DMAX) m_mode[s] = 2;
        end
        exp_busy[s] = (m_mode[s] != 0);
      end
      en_p2 = en_p1; dir_p2 = dir_p1;
      en_p1 = {ren_in, len_in}; dir_p1 = {rdir_in, ldir_in};
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      logic [5:0] act, expv;
      act  = {l_in1, l_in2, r_in1, r_in2, l_busy, r_busy};
      expv = {exp_in1[0], exp_in2[0], exp_in1[1], exp_in2[1], exp_busy[0], exp_busy[1]};
      tests++;
      if (act !== expv) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got %b expected %b", $time, act, expv);
      end
      tests++;
      if ((l_in1 && l_in2) || (r_in1 && r_in2)) begin
        fails++;
        $display("FAIL shoot_through t=%0t l=%b%b r=%b%b expected no pair high", $time, l_in1, l_in2, r_in1, r_in2);
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic edges_until_busy(input int side, input bit val, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((side == 0 ? l_busy : r_busy) == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_pins(input int side, input int n, output int c1, output int c2);
    c1 = 0; c2 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      c1 += (side == 0) ? int'(l_in1) : int'(r_in1);
      c2 += (side == 0) ? int'(l_in2) : int'(r_in2);
    end
  endtask

  task automatic async_reset_pulse(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check(name, int'({l_in1, l_in2, r_in1, r_in2, l_busy, r_busy}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, c1, c2;
    len_in = 1'b1; ldir_in = 1'b1; ren_in = 1'b1; rdir_in = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_hold", int'({l_in1, l_in2, r_in1, r_in2, l_busy, r_busy}), 0);
    len_in = 1'b0; ldir_in = 1'b0; ren_in = 1'b0; rdir_in = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Forward ramp on the left.
    @(negedge clk);
    len_in = 1'b1; ldir_in = 1'b1;
    edges_until_busy(0, 1'b1, 50, n);
    check("busy_latency", n, 3);
    repeat (9 * PERIOD) @(negedge clk);
    count_pins(0, PERIOD, c1, c2);
    check("run_l_in1_high", c1, 255);
    check("run_l_in2_high", c2, 0);

    // Asynchronous reset while running.
    async_reset_pulse("async_rst_run");
    repeat (10 * PERIOD) @(negedge clk);

    // Reversal while running.
    ldir_in = 1'b0;
    edges_until_busy(0, 1'b0, 400, n);
    check("reversal_to_idle", n, 103);
    edges_until_busy(0, 1'b1, 10, n);
    check("idle_gap", n, 1);
    repeat (10 * PERIOD) @(negedge clk);
    count_pins(0, PERIOD, c1, c2);
    check("rev_l_in1_high", c1, 0);
    check("rev_l_in2_high", c2, 255);

    // Stop mid-ramp.
    len_in = 1'b0;
    repeat (150) @(negedge clk);
    len_in = 1'b1; ldir_in = 1'b1;
    repeat (3 * PERIOD + 20) @(negedge clk);
    len_in = 1'b0;
    edges_until_busy(0, 1'b0, 400, n);
    check("stop_to_idle", n, 103);
    count_pins(0, 300, c1, c2);
    check("stop_no_pulses", c1 + c2, 0);

    // Enable drop landing on a period-end cycle.
    len_in = 1'b1;
    repeat (600) @(negedge clk);
    while (cyc % PERIOD != PERIOD - 3) @(negedge clk);
    len_in = 1'b0;
    edges_until_busy(0, 1'b0, 400, n);
    check("abort_on_pe", n, 103);

    // Independent channels: right forward, left reverse 10 clk later.
    ren_in = 1'b1; rdir_in = 1'b1;
    repeat (10) @(negedge clk);
    len_in = 1'b1; ldir_in = 1'b0;
    repeat (4 * PERIOD) @(negedge clk);
    rdir_in = 1'b0;
    count_pins(0, 400, c1, c2);
    check("indep_left_in1", c1, 0);
    check("indep_left_busy", int'(l_busy), 1);

    // Randomized commands, including short pulses and async resets.
    for (int seg = 0; seg < 40; seg++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      {len_in, ldir_in, ren_in, rdir_in} = r;
      if ($urandom_range(0, 7) == 0) async_reset_pulse("async_rst_rand");
      repeat ($urandom_range(1, 700)) @(negedge clk);
    end

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
